// File: rtl/mem_bist_pkg.sv
// Shared types and the address-derived test pattern for the memory port BIST.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    DONE
  } mem_bist_state_e;

  localparam int MEM_BIST_MAX_W = 64;

  // Pattern is computed at the widest supported width; callers truncate to their data width.
  function automatic logic [MEM_BIST_MAX_W-1:0] mem_bist_pat(
    input logic [31:0]               addr,
    input logic [MEM_BIST_MAX_W-1:0] seed,
    input logic                      inv
  );
    logic [MEM_BIST_MAX_W-1:0] p;
    p = seed ^ {32'b0, addr};
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_port_bist_if.sv
// Single-port memory access bundle between the BIST (master) and the memory (slave).
interface mem_port_bist_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  // Handshake: the master holds EN high for exactly one cycle per access, WR qualifies it
  // (1 = write, 0 = read) and Address/Data_in are valid in that same cycle. Writes complete
  // with no response. A read is answered by the slave raising valid_out for one cycle, at
  // least one cycle after the EN cycle, with Data_out valid in that cycle. At most one read
  // is outstanding; there is no back-pressure on EN.
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  EN;
  logic                  WR;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  valid_out;

  modport master (
    output Address, Data_in, EN, WR,
    input  Data_out, valid_out
  );

  modport slave (
    input  Address, Data_in, EN, WR,
    output Data_out, valid_out
  );

endinterface

// File: rtl/mem_port_bist.sv
// Write-then-read-back memory BIST with registered outputs. Optional MEM_BIST_INV_PASS_EN
// adds a second write/read pass using the inverted pattern.
module mem_port_bist
  import mem_bist_pkg::*;
#(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 2**ADDR_WIDTH,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_seen,
  output mem_bist_state_e       dbg_state,
  mem_port_bist_if.master       mem
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT);

  mem_bist_state_e       state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic [ADDR_WIDTH:0]   err_nxt;
  logic [ADDR_WIDTH-1:0] ferr_nxt;
  logic                  tseen_nxt, pass_nxt, busy_nxt, done_nxt;
  logic                  en_q, wr_q, en_nxt, wr_nxt;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_nxt, pat_rd;
  logic                  rec_err, read_end;
  logic                  inv_q, inv_nxt;

`ifdef MEM_BIST_INV_PASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_nxt;
  end
`else
  assign inv_q   = 1'b0;
  assign inv_nxt = 1'b0;
`endif

  assign pat_rd = DATA_WIDTH'(mem_bist_pat(32'(addr), 64'(SEED), inv_q));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wait_nxt  = wait_cnt;
    err_nxt   = err_count;
    ferr_nxt  = first_err_addr;
    tseen_nxt = timeout_seen;
    pass_nxt  = pass;
    rec_err   = 1'b0;
    read_end  = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
    inv_nxt   = inv_q;
`endif
    case (state)
      IDLE: if (start) begin
        err_nxt   = '0;
        ferr_nxt  = '0;
        tseen_nxt = 1'b0;
        pass_nxt  = 1'b0;
        addr_nxt  = '0;
`ifdef MEM_BIST_INV_PASS_EN
        inv_nxt   = 1'b0;
`endif
        state_nxt = WRITE;
      end
      WRITE: begin
        if (addr == LAST_ADDR) begin
          addr_nxt  = '0;
          state_nxt = READ_REQ;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      READ_REQ: begin
        wait_nxt  = '0;
        state_nxt = READ_WAIT;
      end
      READ_WAIT: begin
        // A response wins over the timeout when both land in the same cycle.
        if (mem.valid_out) begin
          read_end = 1'b1;
          rec_err  = (mem.Data_out != pat_rd);
        end else if (wait_cnt == WAIT_LAST) begin
          read_end  = 1'b1;
          rec_err   = 1'b1;
          tseen_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
        if (read_end) begin
          if (addr == LAST_ADDR) begin
`ifdef MEM_BIST_INV_PASS_EN
            if (!inv_q) begin
              inv_nxt   = 1'b1;
              addr_nxt  = '0;
              state_nxt = WRITE;
            end else begin
              state_nxt = DONE;
            end
`else
            state_nxt = DONE;
`endif
          end else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = READ_REQ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (rec_err) begin
      if (err_count == '0) ferr_nxt = addr;
      if (err_count != '1) err_nxt = err_count + 1'b1;
    end
    if (state_nxt == DONE) pass_nxt = (err_nxt == '0);

    // Outputs are registered from next-state values so they line up with the state they describe.
    busy_nxt    = (state_nxt == WRITE) || (state_nxt == READ_REQ) || (state_nxt == READ_WAIT);
    done_nxt    = (state_nxt == DONE);
    en_nxt      = (state_nxt == WRITE) || (state_nxt == READ_REQ);
    wr_nxt      = (state_nxt == WRITE);
    data_in_nxt = (state_nxt == WRITE)
                  ? DATA_WIDTH'(mem_bist_pat(32'(addr_nxt), 64'(SEED), inv_nxt))
                  : data_in_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      wait_cnt       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout_seen   <= 1'b0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      en_q           <= 1'b0;
      wr_q           <= 1'b0;
      data_in_q      <= '0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      wait_cnt       <= wait_nxt;
      err_count      <= err_nxt;
      first_err_addr <= ferr_nxt;
      timeout_seen   <= tseen_nxt;
      pass           <= pass_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      en_q           <= en_nxt;
      wr_q           <= wr_nxt;
      data_in_q      <= data_in_nxt;
    end
  end

  assign mem.EN      = en_q;
  assign mem.WR      = wr_q;
  assign mem.Address = addr;
  assign mem.Data_in = data_in_q;
  assign dbg_state   = state;

endmodule
